// File: rtl/zc_pkg.sv
// -----------------------------------------------------------------------------
// zc_pkg -- shared types for the zero-crossing tracker.
//   zc_state_e   : tracker state (ACQUIRE while learning the signal span,
//                  TRACK while thresholds are valid and crossings are reported)
//   zc_lvl_e     : Schmitt-trigger level of the input relative to the band
//   MODE_*       : encodings of the 2-bit crossing-direction select
//   mode_accepts : whether a crossing of a given direction is reported
// -----------------------------------------------------------------------------
package zc_pkg;

   typedef enum logic {
      ST_ACQUIRE = 1'b0,
      ST_TRACK   = 1'b1
   } zc_state_e;

   typedef enum logic {
      LVL_LOW  = 1'b0,
      LVL_HIGH = 1'b1
   } zc_lvl_e;

   localparam logic [1:0] MODE_RISE     = 2'b00;
   localparam logic [1:0] MODE_FALL     = 2'b01;
   localparam logic [1:0] MODE_BOTH     = 2'b10;
   localparam logic [1:0] MODE_RISE_ALT = 2'b11;

   // The unused encoding 11 behaves exactly like rising-only.
   function automatic logic mode_accepts(input logic [1:0] mode, input logic dir_rising);
      logic ok;
      case (mode)
         MODE_FALL: ok = ~dir_rising;
         MODE_BOTH: ok = 1'b1;
         default:   ok = dir_rising;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/zc_window_minmax.sv
// -----------------------------------------------------------------------------
// zc_window_minmax -- running min/max of enabled samples over fixed windows.
//   clk, reset          : clock, synchronous active-high reset
//   en_i                : sample-valid; the window advances only when high
//   restart_i           : discard the window in progress (from next sample)
//   len_i               : window length in samples (caller guarantees >= 2)
//   data_i              : input sample
//   min_o, max_o        : min/max including the current sample
//   window_done_o       : current enabled sample is the last of the window
// min_o/max_o are folded with the current sample so the caller can latch the
// complete window result on the same edge that window_done_o is high.
// -----------------------------------------------------------------------------
module zc_window_minmax
   import zc_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic              restart_i,
   input  logic [CNT_W-1:0]  len_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] min_o,
   output logic [DATA_W-1:0] max_o,
   output logic              window_done_o
);

   logic [DATA_W-1:0] min_q, min_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign min_o = (data_i < min_q) ? data_i : min_q;
   assign max_o = (data_i > max_q) ? data_i : max_q;
   // >= rather than == so a window length shrunk mid-window still terminates.
   assign window_done_o = en_i && (cnt_q >= len_i - CNT_W'(1));

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      cnt_d = cnt_q;
      if (en_i) begin
         if (restart_i || window_done_o) begin
            min_d = '1;
            max_d = '0;
            cnt_d = '0;
         end else begin
            min_d = min_o;
            max_d = max_o;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         min_q <= '1;
         max_q <= '0;
         cnt_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/zero_cross_tracker.sv
// -----------------------------------------------------------------------------
// zero_cross_tracker -- adaptive-threshold Schmitt zero-crossing detector.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : sample-valid; all state holds while low
//   mode          : 00 rising, 01 falling, 10 both, 11 rising
//   ptos_x_ciclo  : samples per min/max window (values < 2 act as 2)
//   data          : unsigned input sample
//   zero_cross    : one-cycle pulse after a crossing that matches mode
//   rising        : direction of the last crossing (1 = rising)
//   period        : enabled samples between consecutive rising crossings
//   period_valid  : one-cycle pulse when period is updated
//   locked        : high while in TRACK
// Thresholds sit HYST either side of the window midpoint; a watchdog drops
// back to ACQUIRE if nothing crosses within two windows' worth of samples.
// -----------------------------------------------------------------------------
module zero_cross_tracker
   import zc_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int CNT_W  = 16,
   parameter int HYST   = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  ptos_x_ciclo,
   input  logic [DATA_W-1:0] data,
   output logic              zero_cross,
   output logic              rising,
   output logic [CNT_W-1:0]  period,
   output logic              period_valid,
   output logic              locked
);

   localparam logic [DATA_W:0] BAND = (DATA_W+1)'(2*HYST);

   function automatic logic [DATA_W-1:0] sat_hi(input logic [DATA_W-1:0] m);
      logic [DATA_W:0] s;
      s = {1'b0, m} + (DATA_W+1)'(HYST);
      return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] sat_lo(input logic [DATA_W-1:0] m);
      return (m < DATA_W'(HYST)) ? '0 : m - DATA_W'(HYST);
   endfunction

   zc_state_e         state_q, state_d;
   zc_lvl_e           lvl_q, lvl_d;
   logic [DATA_W-1:0] thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d;
   logic              zc_q, zc_d, rise_q, rise_d, pv_q, pv_d;
   logic [CNT_W-1:0]  per_q, per_d, pcnt_q, pcnt_d, pcnt_inc;
   logic              seen_q, seen_d;
   logic [CNT_W:0]    wd_q, wd_d, wd_inc, wd_limit;
   logic              cross_up, cross_dn, win_restart;

   logic [CNT_W-1:0]  win_len;
   logic [DATA_W-1:0] win_min, win_max, span, mid;
   logic              win_done, span_ok;

   assign win_len  = (ptos_x_ciclo < CNT_W'(2)) ? CNT_W'(2) : ptos_x_ciclo;
   assign wd_limit = {win_len, 1'b0};

   zc_window_minmax #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) u_window (
      .clk          (clk),
      .reset        (reset),
      .en_i         (enable),
      .restart_i    (win_restart),
      .len_i        (win_len),
      .data_i       (data),
      .min_o        (win_min),
      .max_o        (win_max),
      .window_done_o(win_done)
   );

   assign span    = win_max - win_min;
   assign mid     = win_min + (span >> 1);
   assign span_ok = {1'b0, span} > BAND;

   assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + CNT_W'(1);
   assign wd_inc   = wd_q + (CNT_W+1)'(1);

   always_comb begin
      state_d     = state_q;
      lvl_d       = lvl_q;
      thr_hi_d    = thr_hi_q;
      thr_lo_d    = thr_lo_q;
      zc_d        = 1'b0;
      pv_d        = 1'b0;
      rise_d      = rise_q;
      per_d       = per_q;
      pcnt_d      = pcnt_q;
      seen_d      = seen_q;
      wd_d        = wd_q;
      win_restart = 1'b0;
      cross_up    = 1'b0;
      cross_dn    = 1'b0;
      if (enable) begin
         pcnt_d = pcnt_inc;
         // New thresholds land in the registers; this sample still sees the old ones.
         if (win_done) begin
            thr_hi_d = sat_hi(mid);
            thr_lo_d = sat_lo(mid);
         end
         if (state_q == ST_ACQUIRE) begin
            if (win_done && span_ok) begin
               state_d = ST_TRACK;
               lvl_d   = (data >= mid) ? LVL_HIGH : LVL_LOW;
               wd_d    = '0;
               seen_d  = 1'b0;
            end
         end else begin
            cross_up = (lvl_q == LVL_LOW)  && (data > thr_hi_q);
            cross_dn = (lvl_q == LVL_HIGH) && (data < thr_lo_q);
            if (cross_up || cross_dn) begin
               lvl_d  = cross_up ? LVL_HIGH : LVL_LOW;
               rise_d = cross_up;
               zc_d   = mode_accepts(mode, cross_up);
               wd_d   = '0;
               if (cross_up) begin
                  pcnt_d = '0;
                  seen_d = 1'b1;
                  // The first rising edge after lock only starts the count.
                  if (seen_q) begin
                     per_d = pcnt_inc;
                     pv_d  = 1'b1;
                  end
               end
            end else if (wd_inc >= wd_limit) begin
               state_d     = ST_ACQUIRE;
               lvl_d       = LVL_LOW;
               wd_d        = '0;
               win_restart = 1'b1;
            end else begin
               wd_d = wd_inc;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_ACQUIRE;
         lvl_q   <= LVL_LOW;
         zc_q    <= 1'b0;
         rise_q  <= 1'b0;
         pv_q    <= 1'b0;
         per_q   <= '0;
         pcnt_q  <= '0;
         seen_q  <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         zc_q    <= zc_d;
         rise_q  <= rise_d;
         pv_q    <= pv_d;
         per_q   <= per_d;
         pcnt_q  <= pcnt_d;
         seen_q  <= seen_d;
         wd_q    <= wd_d;
      end
   end

   // Thresholds are only read in TRACK, which is entered on the same edge
   // that first writes them, so they need no reset.
   always_ff @(posedge clk) begin
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
   end

   assign zero_cross   = zc_q;
   assign rising       = rise_q;
   assign period       = per_q;
   assign period_valid = pv_q;
   assign locked       = (state_q == ST_TRACK);

endmodule
